// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, picks the next fetch address and issues stack micro-ops for interrupt, CALL, RET and RTI.
// Define INT_NEST_MASK_EN to mask nested interrupts inside an ISR and latch requests that arrive while masked or busy.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_001F,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0000,
  parameter int          OP_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [15:0] mem_rdata,
  output logic [31:0] pc,
  output logic [15:0] instr_out,
  input  logic        interrupt,
  input  logic        jump_occured,
  input  logic [15:0] jump_to,
  input  logic        direct_jump,
  input  logic [15:0] direct_jump_to,
  output logic [2:0]  call_reg_sel,
  input  logic [15:0] call_target,
  output logic [2:0]  stack_op,
  output logic [15:0] push_data,
  input  logic        stack_rvalid,
  input  logic [15:0] stack_rdata,
  output logic        busy
);
  typedef enum logic [2:0] {S_FETCH, S_INT_LO, S_INT_FLAGS, S_CALL_LO, S_CALL_JMP, S_POP_LO, S_POP_HI, S_WAIT} state_e;
  localparam logic [15:0] PUSH = {5'd8, 11'd0};
  localparam logic [15:0] POP  = {5'd11, 11'd0};
  state_e state_q;
  logic [31:0] pc_q, pc_inc;
  logic [15:0] instr_q, push_q, lo_q;
  logic [2:0] sel_q, stack_op_q, prev_f;
  logic skip_q, got_lo_q, hazard, int_req;
  logic [OP_W-1:0] op, prev_op;
  assign pc_inc = pc_q + 32'd1;
  assign op = mem_rdata[15 -: OP_W];
  assign prev_op = instr_q[15 -: OP_W];
  // loads name their destination in [7:5], opcode 9 in [10:8]
  assign prev_f = (prev_op == OP_W'(10)) ? instr_q[7:5] : instr_q[10:8];
  assign hazard = (prev_op == OP_W'(10) || prev_op == OP_W'(9)) &&
                  (prev_f == mem_rdata[7:5] || prev_f == mem_rdata[10:8]);
`ifdef INT_NEST_MASK_EN
  logic in_isr_q, int_pend_q, rti_q;
  assign int_req = (interrupt | int_pend_q) & ~in_isr_q;
`else
  assign int_req = interrupt;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      instr_q <= '0;
      stack_op_q <= '0;
      push_q <= '0;
      sel_q <= '0;
      lo_q <= '0;
      skip_q <= 1'b0;
      got_lo_q <= 1'b0;
`ifdef INT_NEST_MASK_EN
      in_isr_q <= 1'b0;
      int_pend_q <= 1'b0;
      rti_q <= 1'b0;
`endif
    end else if (freeze) begin
      instr_q <= '0;
      stack_op_q <= '0;
    end else begin
      instr_q <= '0;
      stack_op_q <= '0;
`ifdef INT_NEST_MASK_EN
      if (interrupt && (in_isr_q || state_q != S_FETCH)) int_pend_q <= 1'b1;
`endif
      case (state_q)
        S_FETCH: begin
          if (jump_occured) pc_q <= {16'b0, jump_to};
          else if (direct_jump) pc_q <= {16'b0, direct_jump_to};
          else if (int_req) begin
            instr_q <= PUSH;
            stack_op_q <= 3'd1;
            push_q <= pc_q[31:16];
            state_q <= S_INT_LO;
`ifdef INT_NEST_MASK_EN
            in_isr_q <= 1'b1;
            int_pend_q <= 1'b0;
`endif
          end else if (op == OP_W'(20)) begin
            instr_q <= PUSH;
            stack_op_q <= 3'd1;
            push_q <= pc_inc[31:16];
            sel_q <= mem_rdata[10:8];
            state_q <= S_CALL_LO;
          end else if (op == OP_W'(21) || op == OP_W'(22)) begin
            instr_q <= POP;
            stack_op_q <= (op == OP_W'(22)) ? 3'd4 : 3'd2;
            skip_q <= (op == OP_W'(22));
            got_lo_q <= 1'b0;
            state_q <= (op == OP_W'(22)) ? S_POP_LO : S_POP_HI;
`ifdef INT_NEST_MASK_EN
            rti_q <= (op == OP_W'(22));
`endif
          end else if (!hazard) begin
            instr_q <= mem_rdata;
            pc_q <= pc_inc;
          end
        end
        S_INT_LO: begin
          instr_q <= PUSH;
          stack_op_q <= 3'd1;
          push_q <= pc_q[15:0];
          state_q <= S_INT_FLAGS;
        end
        S_INT_FLAGS: begin
          stack_op_q <= 3'd3;
          pc_q <= INT_VECTOR;
          state_q <= S_FETCH;
        end
        S_CALL_LO: begin
          instr_q <= PUSH;
          stack_op_q <= 3'd1;
          push_q <= pc_inc[15:0];
          state_q <= S_CALL_JMP;
        end
        S_CALL_JMP: begin
          pc_q <= {16'b0, call_target};
          state_q <= S_FETCH;
        end
        default: begin
          if (state_q != S_WAIT) begin
            instr_q <= POP;
            stack_op_q <= 3'd2;
            state_q <= (state_q == S_POP_LO) ? S_POP_HI : S_WAIT;
          end
          // responses may land while pops are still issuing: flags (RTI), then lo, then hi
          if (stack_rvalid) begin
            if (skip_q) skip_q <= 1'b0;
            else if (!got_lo_q) begin
              lo_q <= stack_rdata;
              got_lo_q <= 1'b1;
            end else begin
              pc_q <= {stack_rdata, lo_q};
              state_q <= S_FETCH;
`ifdef INT_NEST_MASK_EN
              if (rti_q) in_isr_q <= 1'b0;
`endif
            end
          end
        end
      endcase
    end
  end
  assign pc = pc_q;
  assign instr_out = instr_q;
  assign stack_op = stack_op_q;
  assign push_data = push_q;
  assign call_reg_sel = sel_q;
  assign busy = (state_q != S_FETCH);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed walk through the fetch sequences plus randomized fetch/jump and CALL/RET runs checked against a behavioural model.
module tb_fetch_sequencer;
  logic clk = 1'b0, rst = 1'b1, freeze = 1'b0, interrupt = 1'b0;
  logic jump_occured = 1'b0, direct_jump = 1'b0, stack_rvalid = 1'b0;
  logic [15:0] jump_to = '0, direct_jump_to = '0, stack_rdata = '0;
  logic [15:0] mem_rdata, call_target, instr_out, push_data;
  logic [31:0] pc;
  logic [2:0] call_reg_sel, stack_op;
  logic busy;
  logic [15:0] imem [0:255];
  logic [15:0] regs [0:7];
  logic [4:0] ops [0:3];
  logic [15:0] stk [$];
  int checks = 0, errors = 0;
  logic [31:0] exp_pc;
  logic [15:0] w, ei, last, cp, tgt;
  logic jo, dj;
  logic [2:0] r;

  always #5 clk = ~clk;
  assign mem_rdata = imem[pc[7:0]];
  assign call_target = regs[call_reg_sel];

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .freeze(freeze), .mem_rdata(mem_rdata), .pc(pc),
    .instr_out(instr_out), .interrupt(interrupt), .jump_occured(jump_occured),
    .jump_to(jump_to), .direct_jump(direct_jump), .direct_jump_to(direct_jump_to),
    .call_reg_sel(call_reg_sel), .call_target(call_target), .stack_op(stack_op),
    .push_data(push_data), .stack_rvalid(stack_rvalid), .stack_rdata(stack_rdata),
    .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic haz(input logic [15:0] prev, input logic [15:0] word);
    logic [2:0] f;
    f = (prev[15:11] == 5'd10) ? prev[7:5] : prev[10:8];
    return (prev[15:11] == 5'd10 || prev[15:11] == 5'd9) && (f == word[7:5] || f == word[10:8]);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = {5'd1, 11'(i * 7)};
    for (int i = 0; i < 8; i++) regs[i] = 16'(i);
    regs[5] = 16'h0100;
    ops[0] = 5'd1; ops[1] = 5'd2; ops[2] = 5'd9; ops[3] = 5'd10;
    imem[8'h22] = {5'd10, 3'd0, 3'd3, 5'd0};
    imem[8'h23] = {5'd1, 3'd3, 3'd0, 5'd4};
    imem[8'h24] = {5'd21, 11'd0};
    imem[8'h01] = {5'd22, 11'd0};
    imem[8'h40] = {5'd20, 3'd5, 8'd0};
    imem[8'h77] = {5'd21, 11'd0};
    tick;
    chk("rst_pc", pc, 32'h1F);
    chk("rst_instr", 32'(instr_out), 32'h0);
    chk("rst_stack_op", 32'(stack_op), 32'h0);
    chk("rst_push", 32'(push_data), 32'h0);
    chk("rst_sel", 32'(call_reg_sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("seq_pc", pc, 32'h20 + 32'(i));
      chk("seq_instr", 32'(instr_out), 32'(imem[8'h1F + 8'(i)]));
      chk("seq_stack_op", 32'(stack_op), 32'h0);
    end
    tick;
    chk("ld_pc", pc, 32'h23);
    chk("ld_instr", 32'(instr_out), 32'(imem[8'h22]));
    tick;
    chk("stall_pc", pc, 32'h23);
    chk("stall_instr", 32'(instr_out), 32'h0);
    tick;
    chk("after_stall_pc", pc, 32'h24);
    chk("after_stall_instr", 32'(instr_out), 32'(imem[8'h23]));
    tick;
    chk("ret_instr", 32'(instr_out), 32'h5800);
    chk("ret_op", 32'(stack_op), 32'h2);
    chk("ret_busy", 32'(busy), 32'h1);
    stack_rvalid = 1'b1; stack_rdata = 16'h0025;
    tick;
    chk("ret_op2", 32'(stack_op), 32'h2);
    stack_rvalid = 1'b0;
    tick;
    chk("wait_busy", 32'(busy), 32'h1);
    chk("wait_op", 32'(stack_op), 32'h0);
    stack_rvalid = 1'b1; stack_rdata = 16'h0001;
    tick;
    stack_rvalid = 1'b0;
    chk("ret_pc", pc, 32'h0001_0025);
    chk("ret_done_busy", 32'(busy), 32'h0);
    interrupt = 1'b1;
    tick;
    interrupt = 1'b0;
    chk("int_op_hi", 32'(stack_op), 32'h1);
    chk("int_push_hi", 32'(push_data), 32'h0001);
    chk("int_instr", 32'(instr_out), 32'h4000);
    chk("int_busy1", 32'(busy), 32'h1);
    chk("int_pc_hold", pc, 32'h0001_0025);
    tick;
    chk("int_op_lo", 32'(stack_op), 32'h1);
    chk("int_push_lo", 32'(push_data), 32'h0025);
    chk("int_busy2", 32'(busy), 32'h1);
    tick;
    chk("int_op_flags", 32'(stack_op), 32'h3);
    chk("int_vec_pc", pc, 32'h0);
    chk("int_busy3", 32'(busy), 32'h0);
    chk("int_flags_instr", 32'(instr_out), 32'h0);
    tick;
    chk("isr_op", 32'(stack_op), 32'h0);
    chk("isr_pc", pc, 32'h1);
    tick;
    chk("rti_instr", 32'(instr_out), 32'h5800);
    chk("rti_op", 32'(stack_op), 32'h4);
    stack_rvalid = 1'b1; stack_rdata = 16'hF1A6;
    tick;
    chk("rti_op2", 32'(stack_op), 32'h2);
    stack_rdata = 16'h0025;
    tick;
    chk("rti_op3", 32'(stack_op), 32'h2);
    stack_rvalid = 1'b0;
    tick;
    stack_rvalid = 1'b1; stack_rdata = 16'h0001;
    tick;
    stack_rvalid = 1'b0;
    chk("rti_pc", pc, 32'h0001_0025);
    chk("rti_busy", 32'(busy), 32'h0);
    jump_occured = 1'b1; jump_to = 16'h0040; interrupt = 1'b1;
    tick;
    jump_occured = 1'b0; interrupt = 1'b0;
    chk("jmp_pc", pc, 32'h40);
    chk("jmp_instr", 32'(instr_out), 32'h0);
    chk("jmp_over_int", 32'(stack_op), 32'h0);
    tick;
    chk("call_instr", 32'(instr_out), 32'h4000);
    chk("call_op_hi", 32'(stack_op), 32'h1);
    chk("call_push_hi", 32'(push_data), 32'h0000);
    chk("call_sel", 32'(call_reg_sel), 32'h5);
    tick;
    chk("call_op_lo", 32'(stack_op), 32'h1);
    chk("call_push_lo", 32'(push_data), 32'h0041);
    tick;
    chk("call_pc", pc, 32'h0100);
    chk("call_jmp_op", 32'(stack_op), 32'h0);
    chk("call_jmp_busy", 32'(busy), 32'h0);
    jump_occured = 1'b1; jump_to = 16'h0033; direct_jump = 1'b1; direct_jump_to = 16'h0077;
    tick;
    jump_occured = 1'b0;
    chk("jmp_prio_pc", pc, 32'h33);
    tick;
    direct_jump = 1'b0;
    chk("djmp_pc", pc, 32'h77);
    freeze = 1'b1;
    tick;
    freeze = 1'b0;
    chk("frz_pc", pc, 32'h77);
    chk("frz_instr", 32'(instr_out), 32'h0);
    tick;
    tick;
    chk("wait2_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_pc", pc, 32'h1F);
    chk("abort_op", 32'(stack_op), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    stack_rvalid = 1'b1; stack_rdata = 16'hBEEF;
    tick;
    chk("stale_pc1", pc, 32'h20);
    tick;
    stack_rvalid = 1'b0;
    chk("stale_pc2", pc, 32'h21);
    chk("stale_busy", 32'(busy), 32'h0);
    imem[8'h10] = {5'd21, 11'd0};
    jump_occured = 1'b1; jump_to = 16'h0010;
    tick;
    jump_occured = 1'b0;
    tick;
    stack_rvalid = 1'b1; stack_rdata = 16'hFFFF;
    tick;
    tick;
    stack_rvalid = 1'b0;
    chk("max_pc", pc, 32'hFFFF_FFFF);
    tick;
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_instr", 32'(instr_out), 32'(imem[8'hFF]));
    for (int i = 0; i < 256; i++) imem[i] = {ops[$urandom_range(0, 3)], 11'($urandom)};
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_pc = 32'h1F;
    last = '0;
    for (int n = 0; n < 400; n++) begin
      jo = ($urandom_range(0, 15) == 0);
      dj = ($urandom_range(0, 15) == 0);
      jump_occured = jo; jump_to = 16'($urandom);
      direct_jump = dj; direct_jump_to = 16'($urandom);
      w = imem[exp_pc[7:0]];
      tick;
      if (jo) begin exp_pc = {16'b0, jump_to}; ei = '0; end
      else if (dj) begin exp_pc = {16'b0, direct_jump_to}; ei = '0; end
      else if (haz(last, w)) ei = '0;
      else begin ei = w; exp_pc = exp_pc + 32'd1; end
      last = ei;
      chk("rnd_pc", pc, exp_pc);
      chk("rnd_instr", 32'(instr_out), 32'(ei));
    end
    jump_occured = 1'b0; direct_jump = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cp = 16'($urandom_range(16, 240));
      tgt = {8'(k + 1), cp[7:0] + 8'h55};
      r = 3'($urandom_range(0, 7));
      regs[r] = tgt;
      imem[cp[7:0]] = {5'd20, r, 8'($urandom)};
      imem[tgt[7:0]] = {5'd21, 11'($urandom)};
      stk.delete();
      jump_occured = 1'b1; jump_to = cp;
      tick;
      jump_occured = 1'b0;
      for (int c = 0; c < 6; c++) begin
        tick;
        if (stack_op == 3'd1) stk.push_back(push_data);
        if (!busy) break;
      end
      chk("rc_call_pc", pc, {16'b0, tgt});
      chk("rc_depth", 32'(stk.size()), 32'd2);
      for (int c = 0; c < 8; c++) begin
        tick;
        stack_rvalid = 1'b0;
        if (busy && stack_op == 3'd2 && stk.size() > 0) begin
          stack_rvalid = 1'b1;
          stack_rdata = stk.pop_back();
        end
        if (!busy) break;
      end
      stack_rvalid = 1'b0;
      chk("rc_ret_pc", pc, {16'b0, cp} + 32'd1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
